// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if
//   Bundles everything between mult_arbiter and its environment (two
//   requesters plus one shared multiplier).
//   master : requester/multiplier side (drives req*, a*, b*, mul_res, mul_done)
//   slave  : arbiter side (drives gnt*, rsp_*, busy, mul_start, mul_A, mul_B)
interface mult_arbiter_if #(
  parameter int width = 4
);
  logic                 req0;
  logic                 req1;
  logic [width-1:0]     a0;
  logic [width-1:0]     b0;
  logic [width-1:0]     a1;
  logic [width-1:0]     b1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rsp_valid0;
  logic                 rsp_valid1;
  logic [2*width-1:0]   rsp_res;
  logic                 rsp_err;
  logic                 busy;
  logic                 mul_start;
  logic [width-1:0]     mul_A;
  logic [width-1:0]     mul_B;
  logic [2*width-1:0]   mul_res;
  logic                 mul_done;

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_res, mul_done,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_res, rsp_err, busy,
           mul_start, mul_A, mul_B
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_res, mul_done,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_res, rsp_err, busy,
           mul_start, mul_A, mul_B
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter sharing one multiplier between two requesters.
//   Ports:
//     clk   : system clock, all state changes on posedge
//     reset : synchronous active-high reset
//     bus   : mult_arbiter_if.slave (requests/operands in, grants and
//             responses out, multiplier start/operands out, result/done in)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_INIT  | settle 4*width+4 cycles so a stale multiplier op drains
//   S_IDLE  | arbitrate between req0/req1
//   S_GRANT | one-cycle gnt pulse, operands captured at end of cycle
//   S_ISSUE | one-cycle mul_start, timeout counter cleared
//   S_WAIT  | wait for mul_done or timeout
//   S_RESP  | one-cycle rsp_valid, last_served updated
module mult_arbiter #(
  parameter int width   = 4,
  parameter int timeout = 64
) (
  input  logic          clk,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  localparam int SETTLE = 4*width + 4;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_GRANT = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [SW-1:0]       settle_cnt;
  logic [7:0]          tmo_cnt;
  logic                sel;
  logic                last_served;
  logic [width-1:0]    op_a;
  logic [width-1:0]    op_b;
  logic [2*width-1:0]  res_q;
  logic                err_q;

  logic                gnt0_c;
  logic                gnt1_c;
  logic                rsp_valid0_c;
  logic                rsp_valid1_c;
  logic                mul_start_c;
  logic                busy_c;

  logic                settle_done;
  logic                tmo_hit;

  assign settle_done = (settle_cnt == SW'(SETTLE - 1));
  assign tmo_hit     = (tmo_cnt == 8'(timeout - 1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= next_state;
  end

  // next-state logic; mul_done only matters in S_WAIT
  always_comb begin
    next_state = state;
    unique case (state)
      S_INIT:  if (settle_done) next_state = S_IDLE;
      S_IDLE:  if (bus.req0 || bus.req1) next_state = S_GRANT;
      S_GRANT: next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (bus.mul_done || tmo_hit) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_INIT;
    endcase
  end

  // Moore output decode
  always_comb begin
    gnt0_c       = (state == S_GRANT) && !sel;
    gnt1_c       = (state == S_GRANT) &&  sel;
    rsp_valid0_c = (state == S_RESP)  && !sel;
    rsp_valid1_c = (state == S_RESP)  &&  sel;
    mul_start_c  = (state == S_ISSUE);
    busy_c       = (state != S_IDLE);
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      sel         <= 1'b0;
      last_served <= 1'b1;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_INIT: settle_cnt <= settle_cnt + SW'(1);
        S_IDLE: begin
          // on a tie the requester not served last wins
          if (bus.req0 || bus.req1)
            sel <= (bus.req0 && bus.req1) ? ~last_served : bus.req1;
        end
        S_GRANT: begin
          op_a <= sel ? bus.a1 : bus.a0;
          op_b <= sel ? bus.b1 : bus.b0;
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          if (bus.mul_done) begin
            res_q <= bus.mul_res;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: last_served <= sel;
        default: ;
      endcase
    end
  end

  assign bus.gnt0       = gnt0_c;
  assign bus.gnt1       = gnt1_c;
  assign bus.rsp_valid0 = rsp_valid0_c;
  assign bus.rsp_valid1 = rsp_valid1_c;
  assign bus.rsp_res    = res_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_c;
  assign bus.mul_start  = mul_start_c;
  assign bus.mul_A      = op_a;
  assign bus.mul_B      = op_b;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.width(4)) bus();

  mult_arbiter #(.width(4), .timeout(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // multiplier model: samples mul_A/mul_B when it fires done, so operands
  // drifting during WAIT show up as a wrong product
  bit         mul_en  = 1'b1;
  int         mul_lat = 0;
  logic       model_done = 1'b0;
  logic [7:0] model_res  = 8'd0;
  bit         pend = 1'b0;
  int         lat_cnt = 0;
  logic       stray_done = 1'b0;

  assign bus.mul_done = model_done | stray_done;
  assign bus.mul_res  = stray_done ? 8'hAA : model_res;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (!mul_en) begin
      pend <= 1'b0;
    end else if (bus.mul_start === 1'b1) begin
      if (mul_lat == 0) begin
        model_done <= 1'b1;
        model_res  <= {4'b0, bus.mul_A} * {4'b0, bus.mul_B};
      end else begin
        pend    <= 1'b1;
        lat_cnt <= mul_lat - 1;
      end
    end else if (pend) begin
      if (lat_cnt == 0) begin
        model_done <= 1'b1;
        model_res  <= {4'b0, bus.mul_A} * {4'b0, bus.mul_B};
        pend       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // scoreboard: {requester, err, result} and expected grant order
  logic [9:0] exp_q[$];
  bit         gnt_q[$];

  bit saw_gnt, saw_rsp, saw_start;
  int gnt_cnt = 0, rsp_cnt = 0, last_gnt_cyc = 0, gnt_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the next negedge and monitor the outputs of that cycle
  task automatic tick();
    logic [9:0] e;
    bit         g;
    @(negedge clk);
    cyc++;
    saw_gnt   = (bus.gnt0 === 1'b1) || (bus.gnt1 === 1'b1);
    saw_rsp   = (bus.rsp_valid0 === 1'b1) || (bus.rsp_valid1 === 1'b1);
    saw_start = (bus.mul_start === 1'b1);
    check("exclusive_pulses",
          32'($countones({bus.gnt0, bus.gnt1, bus.rsp_valid0, bus.rsp_valid1, bus.mul_start}) > 1), 0);
    if (saw_gnt) begin
      check("gnt_expected", 32'(gnt_q.size() != 0), 1);
      if (gnt_q.size() != 0) begin
        g = gnt_q.pop_front();
        check("gnt_who", 32'({bus.gnt1, bus.gnt0}), g ? 2 : 1);
      end
      gnt_gap      = cyc - last_gnt_cyc;
      last_gnt_cyc = cyc;
      gnt_cnt++;
    end
    if (saw_rsp) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_who_err_res", 32'({bus.rsp_valid1, bus.rsp_err, bus.rsp_res}), 32'(e));
        check("rsp_single_valid", 32'(bus.rsp_valid0 & bus.rsp_valid1), 0);
      end
      rsp_cnt++;
    end
  endtask

  task automatic wait_gnt();
    int n = 0;
    do begin tick(); n++; end while (!saw_gnt && n < 100);
    check("gnt_arrived", 32'(saw_gnt), 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin tick(); n++; end while (!saw_rsp && n < 200);
    check("rsp_arrived", 32'(saw_rsp), 1);
  endtask

  // counts cycles spent in INIT from the cycle reset is released
  task automatic measure_init(input bit inject);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      stray_done = inject && (n == 5);
      tick();
      n++;
    end
    stray_done = 1'b0;
    check("init_length", n, 20);
    check("idle_after_init", 32'(bus.busy), 0);
  endtask

  int n;
  int rsp_base;

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) tick();

    // reset state
    check("reset_busy",      32'(bus.busy), 1);
    check("reset_gnt",       32'({bus.gnt0, bus.gnt1}), 0);
    check("reset_rsp_valid", 32'({bus.rsp_valid0, bus.rsp_valid1}), 0);
    check("reset_mul_start", 32'(bus.mul_start), 0);
    check("reset_rsp_res",   32'(bus.rsp_res), 0);
    check("reset_rsp_err",   32'(bus.rsp_err), 0);
    check("reset_mul_ops",   32'({bus.mul_A, bus.mul_B}), 0);
    reset = 1'b0;
    measure_init(1'b0);

    // single request 7x9
    gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'd63});
    bus.a0 = 4'd7; bus.b0 = 4'd9; bus.req0 = 1'b1;
    wait_gnt();
    tick();
    check("start_after_gnt", 32'(saw_start), 1);
    check("mul_A_7", 32'(bus.mul_A), 7);
    check("mul_B_9", 32'(bus.mul_B), 9);
    bus.req0 = 1'b0; bus.a0 = 4'hC; bus.b0 = 4'h3;
    tick();
    check("start_one_cycle", 32'(bus.mul_start), 0);
    wait_rsp();
    repeat (3) tick();
    check("rsp_res_hold", 32'(bus.rsp_res), 63);
    check("rsp_err_hold", 32'(bus.rsp_err), 0);

    // multiplier never answers: timeout after 64 WAIT cycles
    mul_en = 1'b0;
    gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b1, 8'd0});
    bus.a1 = 4'd2; bus.b1 = 4'd2; bus.req1 = 1'b1;
    wait_gnt();
    tick();
    check("timeout_start", 32'(saw_start), 1);
    bus.req1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!saw_rsp && n < 200);
    check("timeout_wait_plus_resp", n, 65);
    tick();
    check("idle_after_timeout", 32'(bus.busy), 0);
    mul_en = 1'b1;

    // both requesting continuously: strict alternation, starting with 0
    bus.a0 = 4'd3; bus.b0 = 4'd5; bus.a1 = 4'd15; bus.b1 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back(i[0]);
      exp_q.push_back(i[0] ? {1'b1, 1'b0, 8'd225} : {1'b0, 1'b0, 8'd15});
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_gnt();
    wait_gnt();
    check("gnt_gap_1", gnt_gap, 5);
    wait_gnt();
    check("gnt_gap_2", gnt_gap, 5);
    tick();
    bus.req0 = 1'b0;
    wait_gnt();
    check("gnt_gap_3", gnt_gap, 5);
    tick();
    bus.req1 = 1'b0;
    wait_rsp();

    // reset mid-WAIT aborts, stale done during INIT is ignored
    mul_en = 1'b0;
    gnt_q.push_back(1'b0);
    bus.a0 = 4'd4; bus.b0 = 4'd4; bus.req0 = 1'b1;
    wait_gnt();
    tick();
    bus.req0 = 1'b0;
    repeat (3) tick();
    check("in_wait_busy", 32'(bus.busy), 1);
    rsp_base = rsp_cnt;
    reset = 1'b1;
    repeat (2) tick();
    check("abort_busy",    32'(bus.busy), 1);
    check("abort_rsp_res", 32'(bus.rsp_res), 0);
    check("abort_mul_A",   32'(bus.mul_A), 0);
    reset = 1'b0;
    mul_en = 1'b1;
    measure_init(1'b1);
    check("abort_no_rsp", rsp_cnt, rsp_base);
    gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b0, 8'd9});
    bus.a1 = 4'd3; bus.b1 = 4'd3; bus.req1 = 1'b1;
    wait_gnt();
    tick();
    bus.req1 = 1'b0;
    wait_rsp();

    // stray done in IDLE and in GRANT
    repeat (2) tick();
    rsp_base = rsp_cnt;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    check("stray_idle_busy", 32'(bus.busy), 0);
    check("stray_idle_no_rsp", rsp_cnt, rsp_base);
    gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'd0});
    bus.a0 = 4'd0; bus.b0 = 4'd0; bus.req0 = 1'b1;
    wait_gnt();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("stray_grant_issue", 32'(saw_start), 1);
    bus.req0 = 1'b0;
    wait_rsp();

    // upper product bits, multi-cycle multiplier latency
    mul_lat = 3;
    gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b0, 8'd225});
    bus.a1 = 4'd15; bus.b1 = 4'd15; bus.req1 = 1'b1;
    wait_gnt();
    tick();
    bus.req1 = 1'b0; bus.a1 = 4'd1; bus.b1 = 4'd1;
    wait_rsp();

    mul_lat = 1;
    gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'd143});
    bus.a0 = 4'd13; bus.b0 = 4'd11; bus.req0 = 1'b1;
    wait_gnt();
    tick();
    bus.req0 = 1'b0;
    wait_rsp();

    repeat (4) tick();
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("gnt_q_drained", 32'(gnt_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
